// File: rtl/labs_search_ctrl.sv
// Search controller for the E-calculation buffer: streams a contiguous range of candidate
// sequences out, collects in-order E results, and tracks the minimum E and its sequence.
module labs_search_ctrl #(
    parameter int unsigned E_WIDTH      = 20,
    parameter int unsigned SEQ_WIDTH    = 40,
    parameter int unsigned MAX_INFLIGHT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [SEQ_WIDTH-1:0] i_seq_first,
    input  logic [SEQ_WIDTH-1:0] i_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [E_WIDTH-1:0]   o_best_e,
    output logic [SEQ_WIDTH-1:0] o_best_seq,
    output logic                 o_best_valid,
    output logic [SEQ_WIDTH-1:0] o_seq,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic [E_WIDTH-1:0]   i_e,
    input  logic                 i_valid,
    output logic                 o_ready
);
    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CntW-1:0] MaxInflight = CntW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [SEQ_WIDTH-1:0] tx_seq_q, tx_seq_d;
    logic [SEQ_WIDTH-1:0] rx_seq_q, rx_seq_d;
    logic [SEQ_WIDTH-1:0] tx_left_q, tx_left_d;
    logic [SEQ_WIDTH-1:0] rx_left_q, rx_left_d;
    logic [CntW-1:0]      inflight_q, inflight_d;
    logic [E_WIDTH-1:0]   best_e_q, best_e_d;
    logic [SEQ_WIDTH-1:0] best_seq_q, best_seq_d;
    logic                 best_valid_q, best_valid_d;
    logic                 tx_fire, rx_fire, start_ok, active;

    // Handshake outputs depend only on registers (and rst), never on i_ready/i_valid.
    assign active   = (state_q == StRun) || (state_q == StDrain);
    assign o_valid  = ~rst & (state_q == StRun) & (tx_left_q != '0) & (inflight_q < MaxInflight);
    assign o_ready  = ~rst & active & (rx_left_q != '0);
    assign tx_fire  = o_valid & i_ready;
    assign rx_fire  = o_ready & i_valid;
    assign start_ok = i_start & ((state_q == StIdle) || (state_q == StDone));

    assign o_busy       = active;
    assign o_done       = (state_q == StDone);
    assign o_seq        = tx_seq_q;
    assign o_best_e     = best_e_q;
    assign o_best_seq   = best_seq_q;
    assign o_best_valid = best_valid_q;

    always_comb begin
        state_d      = state_q;
        tx_seq_d     = tx_seq_q;
        rx_seq_d     = rx_seq_q;
        tx_left_d    = tx_left_q;
        rx_left_d    = rx_left_q;
        inflight_d   = inflight_q;
        best_e_d     = best_e_q;
        best_seq_d   = best_seq_q;
        best_valid_d = best_valid_q;

        if (start_ok) begin
            tx_seq_d     = i_seq_first;
            rx_seq_d     = i_seq_first;
            tx_left_d    = i_count;
            rx_left_d    = i_count;
            inflight_d   = '0;
            best_e_d     = '1;
            best_valid_d = 1'b0;
            state_d      = (i_count == '0) ? StDone : StRun;
        end else begin
            if (tx_fire) begin
                tx_seq_d  = tx_seq_q + SEQ_WIDTH'(1);
                tx_left_d = tx_left_q - SEQ_WIDTH'(1);
            end
            if (rx_fire) begin
                // Strict compare keeps the earliest sequence on ties.
                if (i_e < best_e_q) begin
                    best_e_d   = i_e;
                    best_seq_d = rx_seq_q;
                end
                best_valid_d = 1'b1;
                rx_seq_d     = rx_seq_q + SEQ_WIDTH'(1);
                rx_left_d    = rx_left_q - SEQ_WIDTH'(1);
            end
            case ({tx_fire, rx_fire})
                2'b10:   inflight_d = inflight_q + CntW'(1);
                2'b01:   inflight_d = inflight_q - CntW'(1);
                default: inflight_d = inflight_q;
            endcase
            if (rx_fire && (rx_left_q == SEQ_WIDTH'(1))) begin
                state_d = StDone;
            end else if (tx_fire && (tx_left_q == SEQ_WIDTH'(1))) begin
                state_d = StDrain;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tx_seq_q     <= '0;
            rx_seq_q     <= '0;
            tx_left_q    <= '0;
            rx_left_q    <= '0;
            inflight_q   <= '0;
            best_e_q     <= '1;
            best_seq_q   <= '0;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_seq_q     <= tx_seq_d;
            rx_seq_q     <= rx_seq_d;
            tx_left_q    <= tx_left_d;
            rx_left_q    <= rx_left_d;
            inflight_q   <= inflight_d;
            best_e_q     <= best_e_d;
            best_seq_q   <= best_seq_d;
            best_valid_q <= best_valid_d;
        end
    end

endmodule

// File: tb/tb_labs_search_ctrl.sv
// Bench for labs_search_ctrl: table of whole searches, hand-written corner sequences, and
// randomized searches, all checked every cycle against a count-based search model.
module tb_labs_search_ctrl;
    localparam int unsigned EW = 20;
    localparam int unsigned SW = 40;
    localparam int unsigned MI = 4;
    localparam longint unsigned SeqMask = (64'd1 << SW) - 64'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [SW-1:0] i_seq_first = '0;
    logic [SW-1:0] i_count = '0;
    logic          o_busy, o_done, o_best_valid, o_valid, o_ready;
    logic [EW-1:0] o_best_e;
    logic [SW-1:0] o_best_seq, o_seq;
    logic          i_ready = 1'b0;
    logic [EW-1:0] i_e = '0;
    logic          i_valid = 1'b0;

    always #5 clk = ~clk;

    labs_search_ctrl #(
        .E_WIDTH     (EW),
        .SEQ_WIDTH   (SW),
        .MAX_INFLIGHT(MI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_seq_first (i_seq_first),
        .i_count     (i_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_best_e    (o_best_e),
        .o_best_seq  (o_best_seq),
        .o_best_valid(o_best_valid),
        .o_seq       (o_seq),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .i_e         (i_e),
        .i_valid     (i_valid),
        .o_ready     (o_ready)
    );

    int checks = 0;
    int errors = 0;

    // Search model: a search is just "count results, issued/received so far, running min".
    bit              m_active;
    longint unsigned m_first, m_count, m_issued, m_received, m_best_seq;
    logic [EW-1:0]   m_best_e;
    bit              m_best_valid;
    logic [EW-1:0]   e_src[$];

    typedef struct {
        logic [SW-1:0]        first;
        longint unsigned      count;
        logic [3:0][EW-1:0]   es;
        logic [EW-1:0]        best_e;
        logic [SW-1:0]        best_seq;
        bit                   best_valid;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [SW-1:0] first, input longint unsigned count,
                                input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                                input logic [EW-1:0] e2, input logic [EW-1:0] e3,
                                input logic [EW-1:0] be, input logic [SW-1:0] bs,
                                input bit bv);
        vec_t v;
        v.first = first; v.count = count;
        v.es[0] = e0; v.es[1] = e1; v.es[2] = e2; v.es[3] = e3;
        v.best_e = be; v.best_seq = bs; v.best_valid = bv;
        return v;
    endfunction

    function automatic bit exp_busy();
        return m_active && (m_received < m_count);
    endfunction

    function automatic bit exp_valid();
        return exp_busy() && (m_issued < m_count) && ((m_issued - m_received) < MI);
    endfunction

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_first = 0; m_count = 0; m_issued = 0; m_received = 0;
        m_best_e = '1; m_best_seq = 0; m_best_valid = 0;
        e_src.delete();
    endtask

    // Compare outputs with the model, advance the model by this cycle's inputs, then clock.
    task automatic cycle();
        bit tx, rx;
        chk("busy", o_busy, exp_busy());
        chk("done", o_done, m_active && (m_received == m_count));
        chk("valid", o_valid, exp_valid());
        chk("ready", o_ready, exp_busy());
        chk("seq", o_seq, (m_first + m_issued) & SeqMask);
        chk("best_e", o_best_e, m_best_e);
        chk("best_seq", o_best_seq, m_best_seq);
        chk("best_valid", o_best_valid, m_best_valid);
        if (i_start && !exp_busy()) begin
            m_active = 1; m_first = i_seq_first; m_count = i_count;
            m_issued = 0; m_received = 0; m_best_e = '1; m_best_valid = 0;
        end else begin
            tx = exp_valid() && i_ready;
            rx = i_valid && exp_busy();
            if (rx) begin
                if (i_e < m_best_e) begin
                    m_best_e   = i_e;
                    m_best_seq = (m_first + m_received) & SeqMask;
                end
                m_best_valid = 1;
                m_received++;
                if (e_src.size() > 0) void'(e_src.pop_front());
            end
            if (tx) m_issued++;
        end
        @(posedge clk);
        #1;
    endtask

    // Behaves like the E buffer: answers only sequences it was given, in order.
    task automatic drive(input int rdy_pct, input int vld_pct);
        i_ready = ($urandom_range(99) < rdy_pct);
        i_valid = (m_issued > m_received) && ($urandom_range(99) < vld_pct);
        i_e = (e_src.size() > 0) ? e_src[0] : EW'($urandom_range(15));
    endtask

    task automatic start_search(input logic [SW-1:0] first, input longint unsigned count);
        i_start = 1'b1; i_seq_first = first; i_count = SW'(count);
        drive(0, 0);
        cycle();
        i_start = 1'b0;
        i_seq_first = SW'({$urandom(), $urandom()});
        i_count = SW'({$urandom(), $urandom()});
    endtask

    task automatic run_to_done(input int rdy, input int vld, input bit poke, input int budget);
        int n = 0;
        while (exp_busy() && n < budget) begin
            drive(rdy, vld);
            i_start = poke && ($urandom_range(9) == 0);
            cycle();
            n++;
        end
        i_start = 1'b0;
        checks++;
        if (exp_busy()) begin
            errors++;
            $display("FAIL budget: search still busy after %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        model_reset();
        rst = 1'b0;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_best_e", o_best_e, 20'hFFFFF);
        chk("rst_best_seq", o_best_seq, 0);
        chk("rst_best_valid", o_best_valid, 0);
        chk("rst_seq", o_seq, 0);
    endtask

    initial begin
        int xfers;
        vecs[0] = mk(40'h5, 4, 20'd10, 20'd7, 20'd7, 20'd12, 20'd7, 40'h6, 1'b1);
        vecs[1] = mk(40'hFFFFFFFFFE, 3, 20'd9, 20'd8, 20'd2, 20'd0, 20'd2, 40'h0, 1'b1);
        vecs[2] = mk(40'h123, 0, 20'd0, 20'd0, 20'd0, 20'd0, 20'hFFFFF, 40'h0, 1'b0);
        vecs[3] = mk(40'd100, 2, 20'hFFFFF, 20'hFFFFF, 20'd0, 20'd0, 20'hFFFFF, 40'h0, 1'b1);
        vecs[4] = mk(40'h7, 4, 20'd5, 20'd5, 20'd5, 20'd5, 20'd5, 40'h7, 1'b1);
        vecs[5] = mk(40'h1, 1, 20'd0, 20'd3, 20'd3, 20'd3, 20'd0, 40'h1, 1'b1);

        model_reset();
        do_reset();
        cycle();

        foreach (vecs[i]) begin
            e_src.delete();
            for (int k = 0; k < int'(vecs[i].count); k++) e_src.push_back(vecs[i].es[k]);
            start_search(vecs[i].first, vecs[i].count);
            run_to_done(100, 60, 1'b0, 200);
            chk("tbl_done", o_done, 1);
            chk("tbl_valid", o_valid, 0);
            chk("tbl_best_e", o_best_e, vecs[i].best_e);
            chk("tbl_best_seq", o_best_seq, vecs[i].best_seq);
            chk("tbl_best_valid", o_best_valid, vecs[i].best_valid);
            chk("tbl_end_seq", o_seq, (longint'(vecs[i].first) + vecs[i].count) & SeqMask);
        end

        // Credit limit: no results returned, so exactly MI transfers, then one per result.
        start_search(40'd200, 10);
        xfers = 0;
        for (int c = 0; c < 8; c++) begin
            i_ready = 1'b1; i_valid = 1'b0;
            if (o_valid) xfers++;
            cycle();
        end
        chk("cap_xfers", xfers, 4);
        chk("cap_valid", o_valid, 0);
        i_valid = 1'b1; i_e = 20'd3;
        cycle();
        xfers = 0;
        for (int c = 0; c < 4; c++) begin
            i_ready = 1'b1; i_valid = 1'b0;
            if (o_valid) xfers++;
            cycle();
        end
        chk("cap_one_more", xfers, 1);
        run_to_done(100, 50, 1'b0, 200);

        // Reset mid-run after three transfers; a start during RUN must be ignored.
        start_search(40'd50, 10);
        for (int c = 0; c < 3; c++) begin
            i_ready = 1'b1; i_valid = 1'b0;
            i_start = (c == 1);
            i_seq_first = 40'd999; i_count = 40'd1;
            cycle();
        end
        i_start = 1'b0;
        chk("mid_seq", o_seq, 53);
        chk("mid_busy", o_busy, 1);
        do_reset();
        cycle();

        // Randomized searches with back-pressure, ignored starts and wrap-around ranges.
        for (int s = 0; s < 20; s++) begin
            logic [SW-1:0] first;
            first = (s % 3 == 0) ? SW'(SeqMask - longint'($urandom_range(5)))
                                 : SW'({$urandom(), $urandom()});
            start_search(first, $urandom_range(24, 1));
            run_to_done($urandom_range(100, 30), $urandom_range(100, 30), 1'b1, 2000);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
